// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset release sequencer.
// Imported by reset_release_seq and its rstb_filter sub-module.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    ASSERT  = 2'd3
  } seq_state_e;

  localparam int DEF_N_STAGES    = 4;
  localparam int DEF_STAGE_DELAY = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CYCLES = 4;

endpackage

// File: rtl/reset_release_seq_rstb_filter.sv
// Pad-input synchronizer plus debounce: the filtered output only changes after
// the synchronized input has disagreed with it for FILT_CYCLES cycles in a row.
module rstb_filter
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILT_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Chain presets high so the debounce window opens as soon as reset lifts;
  // the filtered output itself still starts asserted and must be qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(FILT_CYCLES - 1)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/reset_release_seq.sv
// Releases N_STAGES active-low domain resets in order with STAGE_DELAY spacing
// after POR and a debounced pad reset; re-asserts them in reverse order.
module reset_release_seq
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic                clk,
  input  logic                porb_l,
  input  logic                rstb_in,
  input  logic                sw_rst_req,
  output logic                sw_rst_ack,
  output logic [N_STAGES-1:0] rstb_out,
  output logic                seq_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(STAGE_DELAY) + 1;
  localparam int IDX_W = $clog2(N_STAGES);

  logic [SYNC_STAGES-1:0] por_sync_q;
  logic                   por_sync;
  logic                   filt_rstb;

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_STAGES-1:0] rstb_out_q, rstb_out_d;
  logic                seq_done_q, seq_done_d;
  logic                ack_q, ack_d;

  always_ff @(posedge clk or negedge porb_l) begin
    if (!porb_l) begin
      por_sync_q <= '0;
    end else begin
      por_sync_q <= {por_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign por_sync = por_sync_q[SYNC_STAGES-1];

  rstb_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_rstb_filter (
    .clk   (clk),
    .rst_n (porb_l),
    .pad_i (rstb_in),
    .filt_o(filt_rstb)
  );

  always_ff @(posedge clk or negedge porb_l) begin
    if (!porb_l) begin
      state_q    <= HOLD;
      idx_q      <= '0;
      cnt_q      <= '0;
      rstb_out_q <= '0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rstb_out_q <= rstb_out_d;
      seq_done_q <= seq_done_d;
      ack_q      <= ack_d;
    end
  end

  // Releases shift a 1 in from bit 0 and assertion shifts right, so the
  // output stays thermometer-coded in every state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rstb_out_d = rstb_out_q;
    seq_done_d = seq_done_q;
    ack_d      = 1'b0;
    case (state_q)
      HOLD: begin
        rstb_out_d = '0;
        seq_done_d = 1'b0;
        if (por_sync && filt_rstb) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = CNT_W'(STAGE_DELAY - 1);
        end
      end
      RELEASE: begin
        if (!filt_rstb) begin
          state_d = ASSERT;
        end else if (cnt_q == '0) begin
          rstb_out_d = {rstb_out_q[N_STAGES-2:0], 1'b1};
          cnt_d      = CNT_W'(STAGE_DELAY - 1);
          if (idx_q == IDX_W'(N_STAGES - 1)) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (!filt_rstb) begin
          state_d    = ASSERT;
          seq_done_d = 1'b0;
        end else if (sw_rst_req) begin
          state_d    = ASSERT;
          seq_done_d = 1'b0;
          ack_d      = 1'b1;
        end
      end
      ASSERT: begin
        if (rstb_out_q == '0) begin
          state_d = HOLD;
        end else begin
          rstb_out_d = rstb_out_q >> 1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    busy       = (state_q == RELEASE) || (state_q == ASSERT);
    rstb_out   = rstb_out_q;
    seq_done   = seq_done_q;
    sw_rst_ack = ack_q;
  end

endmodule

// File: tb/tb_reset_release_seq.sv
// Self-checking bench: directed scenarios plus random pad/software resets, all
// compared every cycle against a time-based behavioural model of the sequencer.
module tb_reset_release_seq;

  localparam int N    = 4;
  localparam int SD   = 8;
  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic         clk = 1'b0;
  logic         porb_l = 1'b1;
  logic         rstb_in = 1'b1;
  logic         sw_rst_req = 1'b0;
  logic         sw_rst_ack;
  logic [N-1:0] rstb_out;
  logic         seq_done;
  logic         busy;

  int errors = 0;
  int checks = 0;

  reset_release_seq #(
    .N_STAGES(N), .STAGE_DELAY(SD), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)
  ) dut (
    .clk(clk), .porb_l(porb_l), .rstb_in(rstb_in), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack), .rstb_out(rstb_out), .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstb, input logic req, input int cycles);
    rstb_in    = rstb;
    sw_rst_req = req;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitOut(input logic [N-1:0] val, input int maxCycles, input string name);
    int n = 0;
    while (rstb_out !== val && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(rstb_out === val), 32'd1);
  endtask

  // Model: phase 0 hold, 1 releasing, 2 running, 3 asserting; mLevel = released stages.
  int  mPorCnt = 0, mRun = 0, mPhase = 0, mLevel = 0, mElapsed = 0;
  bit  mFilt = 0, mAck = 0;
  bit  mSyncQ[$];

  always @(posedge clk or negedge porb_l) begin
    bit oldPorSync, oldFilt, syncOut;
    if (!porb_l) begin
      mPorCnt = 0; mRun = 0; mPhase = 0; mLevel = 0; mElapsed = 0;
      mFilt = 0; mAck = 0;
      mSyncQ.delete();
      for (int i = 0; i < SYNC; i++) mSyncQ.push_back(1'b1);
    end else begin
      oldPorSync = (mPorCnt >= SYNC);
      oldFilt    = mFilt;
      mAck       = 0;
      case (mPhase)
        0: if (oldPorSync && oldFilt) begin mPhase = 1; mElapsed = 0; end
        1: if (!oldFilt) mPhase = 3;
           else begin
             mElapsed++;
             if (mElapsed % SD == 0) begin
               mLevel++;
               if (mLevel == N) mPhase = 2;
             end
           end
        2: if (!oldFilt) mPhase = 3;
           else if (sw_rst_req) begin mAck = 1; mPhase = 3; end
        default: if (mLevel == 0) mPhase = 0; else mLevel--;
      endcase
      syncOut = mSyncQ.pop_front();
      mSyncQ.push_back(rstb_in);
      if (syncOut != mFilt) begin
        mRun++;
        if (mRun == FILT) begin mFilt = !mFilt; mRun = 0; end
      end else begin
        mRun = 0;
      end
      if (mPorCnt < 1000) mPorCnt++;
    end
  end

  always @(negedge clk) begin
    checkOutput("rstb_out", 32'(rstb_out), 32'((1 << mLevel) - 1));
    checkOutput("seq_done", 32'(seq_done), 32'(mPhase == 2));
    checkOutput("busy", 32'(busy), 32'(mPhase == 1 || mPhase == 3));
    checkOutput("sw_rst_ack", 32'(sw_rst_ack), 32'(mAck));
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstEdge[N];
    int ackCount;
    logic [N-1:0] maxSeen;
    logic [N-1:0] padSeq[4];
    int n, runLeft;
    logic curRstb;
    padSeq = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};

    // Power-up: POR low until 30 ns, pad reset high throughout
    #1 porb_l = 1'b0;
    #9;
    checkOutput("reset_rstb_out", 32'(rstb_out), 32'd0);
    checkOutput("reset_seq_done", 32'(seq_done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ack", 32'(sw_rst_ack), 32'd0);
    #20 porb_l = 1'b1;
    for (int k = 0; k < N; k++) firstEdge[k] = 0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (firstEdge[k] == 0 && rstb_out == N'((1 << (k + 1)) - 1)) firstEdge[k] = e;
    end
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("stage%0d_edge", k), 32'(firstEdge[k]), 32'(13 + SD * k));
    checkOutput("powerup_done", 32'(seq_done), 32'd1);

    // Glitch rejection
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("glitch_rstb_out", 32'(rstb_out), 32'hF);
    checkOutput("glitch_done", 32'(seq_done), 32'd1);

    // Pad reset
    rstb_in = 1'b0;
    n = 0;
    while (seq_done && n < 20) begin @(negedge clk); n++; end
    checkOutput("pad_done_fall", 32'(seq_done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); n++;
      checkOutput($sformatf("pad_seq%0d", k), 32'(rstb_out), 32'(padSeq[k]));
    end
    if (n < 20) repeat (20 - n) @(negedge clk);
    rstb_in = 1'b1;
    waitOut(4'hF, 80, "pad_rerelease");

    // Software reset: one ack, reverse assertion, automatic re-release
    @(negedge clk);
    ackCount = 0;
    sw_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); ackCount += int'(sw_rst_ack); end
    sw_rst_req = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); ackCount += int'(sw_rst_ack); end
    checkOutput("sw_ack_count", 32'(ackCount), 32'd1);
    waitOut(4'hF, 40, "sw_rerelease");

    // Abort mid-release, with an ignored software request during RELEASE
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 10);
    rstb_in = 1'b1;
    waitOut(4'b0001, 60, "abort_reach_0001");
    ackCount = 0;
    sw_rst_req = 1'b1;
    @(negedge clk); ackCount += int'(sw_rst_ack);
    sw_rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); ackCount += int'(sw_rst_ack); end
    checkOutput("release_no_ack", 32'(ackCount), 32'd0);
    waitOut(4'b0011, 20, "abort_reach_0011");
    rstb_in = 1'b0;
    maxSeen = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rstb_out > maxSeen) maxSeen = rstb_out;
    end
    checkOutput("abort_no_new_bit", 32'(maxSeen), 32'b0011);
    checkOutput("abort_cleared", 32'(rstb_out), 32'd0);
    rstb_in = 1'b1;
    waitOut(4'hF, 80, "abort_rerelease");

    // Asynchronous POR mid-release
    rstb_in = 1'b0;
    repeat (12) @(negedge clk);
    rstb_in = 1'b1;
    waitOut(4'b0001, 60, "por_reach_release");
    @(posedge clk);
    #2 porb_l = 1'b0;
    #1;
    checkOutput("por_async_rstb", 32'(rstb_out), 32'd0);
    checkOutput("por_async_done", 32'(seq_done), 32'd0);
    checkOutput("por_async_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #2 porb_l = 1'b1;
    waitOut(4'hF, 60, "por_rerelease");

    // Random pad glitches and software requests against the model
    @(negedge clk);
    runLeft = 0;
    curRstb = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (runLeft == 0) begin
        curRstb = !curRstb;
        runLeft = curRstb ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      end
      rstb_in    = curRstb;
      sw_rst_req = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      runLeft--;
    end
    applyStimulus(1'b1, 1'b0, 5);
    waitOut(4'hF, 80, "random_final_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
